// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the buffered UART bridge (TX drain FSM encoding,
// byte width and the FIFO level-width helper).
package uart_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_BUSY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic int unsigned level_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers and a registered head output
// that is valid in the same cycle the FIFO becomes non-empty.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned Width = BYTE_W,
   parameter int unsigned Depth = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_push,
   input  logic [Width-1:0]            i_wdata,
   input  logic                        i_pop,
   output logic [Width-1:0]            o_rdata,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [level_w(Depth)-1:0]   o_level
);

   localparam int unsigned AW = $clog2(Depth);
   localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

   logic [Width-1:0] r_mem [Depth];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [Width-1:0] r_rdata;
   logic             w_push;
   logic             w_pop;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_next;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop     = i_pop && !o_empty;
   assign w_push    = i_push && (!o_full || w_pop);
   assign w_wr_idx  = r_wr_ptr[AW-1:0];
   assign w_rd_next = r_rd_ptr[AW-1:0] + AW'(w_pop);
   assign o_level   = r_wr_ptr - r_rd_ptr;
   assign o_rdata   = r_rdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_rdata  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_INC;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_INC;
         // head register tracks the next read slot; bypass when that slot is written now
         r_rdata <= (w_push && (w_wr_idx == w_rd_next)) ? i_wdata : r_mem[w_rd_next];
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[w_wr_idx] <= i_wdata;
   end

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART transmitter/receiver; DIN accepted when OE=1 and RDY=1,
// INT pulses for one cycle with DOUT when a frame with a valid stop bit arrives.
module uart_core #(
   parameter int unsigned Bauds = 9_600,
   parameter int unsigned Fclk  = 50_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       OE,
   input  logic [7:0] DIN,
   output logic       RDY,
   output logic [7:0] DOUT,
   output logic       INT,
   output logic       TXD,
   input  logic       RXD
);

   localparam int unsigned DIV = Fclk / Bauds;
   localparam int unsigned CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

   logic [9:0]    r_tx_sh;
   logic [3:0]    r_tx_bits;
   logic [CW-1:0] r_tx_cnt;
   logic          r_tx_busy;

   logic [1:0]    r_sync;
   logic          r_rx_act;
   logic [CW-1:0] r_rx_cnt;
   logic [3:0]    r_rx_bits;
   logic [7:0]    r_rx_sh;
   logic          r_int;
   logic [7:0]    r_dout;
   logic [CW-1:0] w_rx_target;

   assign RDY  = !r_tx_busy;
   assign TXD  = r_tx_sh[0];
   assign INT  = r_int;
   assign DOUT = r_dout;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_tx_sh   <= '1;
         r_tx_bits <= '0;
         r_tx_cnt  <= '0;
         r_tx_busy <= 1'b0;
      end else if (!r_tx_busy) begin
         if (OE) begin
            r_tx_sh   <= {1'b1, DIN, 1'b0};
            r_tx_bits <= 4'd10;
            r_tx_cnt  <= '0;
            r_tx_busy <= 1'b1;
         end
      end else if (r_tx_cnt == BIT_END) begin
         r_tx_cnt  <= '0;
         r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
         r_tx_bits <= r_tx_bits - 4'd1;
         if (r_tx_bits == 4'd1) r_tx_busy <= 1'b0;
      end else begin
         r_tx_cnt <= r_tx_cnt + CW'(1);
      end
   end

   // first wait lands mid start bit, later waits are whole bit periods
   assign w_rx_target = (r_rx_bits == 4'd0) ? HALF_END : BIT_END;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync    <= '1;
         r_rx_act  <= 1'b0;
         r_rx_cnt  <= '0;
         r_rx_bits <= '0;
         r_rx_sh   <= '0;
         r_int     <= 1'b0;
         r_dout    <= '0;
      end else begin
         r_sync <= {r_sync[0], RXD};
         r_int  <= 1'b0;
         if (!r_rx_act) begin
            if (!r_sync[1]) begin
               r_rx_act  <= 1'b1;
               r_rx_cnt  <= '0;
               r_rx_bits <= '0;
            end
         end else if (r_rx_cnt != w_rx_target) begin
            r_rx_cnt <= r_rx_cnt + CW'(1);
         end else begin
            r_rx_cnt <= '0;
            if (r_rx_bits == 4'd0) begin
               if (r_sync[1]) r_rx_act <= 1'b0;
               else           r_rx_bits <= 4'd1;
            end else if (r_rx_bits == 4'd9) begin
               r_rx_act <= 1'b0;
               if (r_sync[1]) begin
                  r_int  <= 1'b1;
                  r_dout <= r_rx_sh;
               end
            end else begin
               r_rx_sh   <= {r_sync[1], r_rx_sh[7:1]};
               r_rx_bits <= r_rx_bits + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge: UART core with TX/RX FIFOs exposed as valid/ready byte streams.
// Define UART_ECHO_EN to loop every accepted RX byte back into the TX FIFO.
`ifndef FCLK
`define FCLK 50_000_000
`endif

module uart_stream_bridge
   import uart_pkg::*;
#(
   parameter int unsigned Bauds   = 9_600,
   parameter int unsigned Fclk    = `FCLK,
   parameter int unsigned TxDepth = 16,
   parameter int unsigned RxDepth = 16
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic [BYTE_W-1:0]             TX_DATA,
   input  logic                          TX_VALID,
   output logic                          TX_READY,
   output logic [BYTE_W-1:0]             RX_DATA,
   output logic                          RX_VALID,
   input  logic                          RX_READY,
   output logic [level_w(TxDepth)-1:0]   TX_LEVEL,
   output logic [level_w(RxDepth)-1:0]   RX_LEVEL,
   output logic                          RX_OVF,
   input  logic                          OVF_CLR,
   output logic                          IRQ,
   output logic                          TXD,
   input  logic                          RXD
);

   logic [1:0]        r_state;
   logic              r_ovf;
   logic              w_core_rst;
   logic              w_oe;
   logic              w_rdy;
   logic              w_int;
   logic [BYTE_W-1:0] w_dout;
   logic [BYTE_W-1:0] w_tx_head;
   logic [BYTE_W-1:0] w_tx_wdata;
   logic              w_tx_push;
   logic              w_tx_full;
   logic              w_tx_empty;
   logic              w_rx_full;
   logic              w_rx_empty;
   logic              w_rx_pop;
   logic              w_ovf_set;

   assign w_core_rst = !RSTN;
   assign w_oe       = (r_state == ST_LOAD);
   assign RX_VALID   = !w_rx_empty;
   assign w_rx_pop   = RX_VALID && RX_READY;
   assign w_ovf_set  = w_int && w_rx_full && !w_rx_pop;
   assign RX_OVF     = r_ovf;
   assign IRQ        = RX_VALID || r_ovf;

`ifdef UART_ECHO_EN
   logic w_echo;
   assign w_echo     = w_int && (!w_rx_full || w_rx_pop);
   assign TX_READY   = !w_tx_full && !w_echo;
   assign w_tx_push  = w_echo || (TX_VALID && TX_READY);
   assign w_tx_wdata = w_echo ? w_dout : TX_DATA;
`else
   assign TX_READY   = !w_tx_full;
   assign w_tx_push  = TX_VALID && TX_READY;
   assign w_tx_wdata = TX_DATA;
`endif

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (!w_tx_empty && w_rdy) r_state <= ST_LOAD;
            ST_LOAD: r_state <= ST_BUSY;
            ST_BUSY: if (!w_rdy) r_state <= ST_DONE;
            ST_DONE: if (w_rdy) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)          r_ovf <= 1'b0;
      else if (w_ovf_set) r_ovf <= 1'b1;
      else if (OVF_CLR)   r_ovf <= 1'b0;
   end

   sync_fifo #(.Width(BYTE_W), .Depth(TxDepth)) u_tx_fifo (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_push  (w_tx_push),
      .i_wdata (w_tx_wdata),
      .i_pop   (w_oe),
      .o_rdata (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_level (TX_LEVEL)
   );

   sync_fifo #(.Width(BYTE_W), .Depth(RxDepth)) u_rx_fifo (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_push  (w_int),
      .i_wdata (w_dout),
      .i_pop   (w_rx_pop),
      .o_rdata (RX_DATA),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_level (RX_LEVEL)
   );

   uart_core #(.Bauds(Bauds), .Fclk(Fclk)) u_core (
      .CLK  (CLK),
      .RST  (w_core_rst),
      .OE   (w_oe),
      .DIN  (w_tx_head),
      .RDY  (w_rdy),
      .DOUT (w_dout),
      .INT  (w_int),
      .TXD  (TXD),
      .RXD  (RXD)
   );

endmodule

// File: tb/tb_uart_stream_bridge.sv
// tb_uart_stream_bridge: randomized stimulus against queue-based TX/RX reference models.
module tb_uart_stream_bridge;

   localparam int unsigned DIV      = 8;
   localparam int unsigned TX_DEPTH = 4;
   localparam int unsigned RX_DEPTH = 4;

   logic       CLK      = 1'b0;
   logic       RSTN     = 1'b1;
   logic [7:0] TX_DATA  = '0;
   logic       TX_VALID = 1'b0;
   logic       TX_READY;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       RX_READY = 1'b0;
   logic [2:0] TX_LEVEL;
   logic [2:0] RX_LEVEL;
   logic       RX_OVF;
   logic       OVF_CLR  = 1'b0;
   logic       IRQ;
   logic       TXD;
   logic       RXD      = 1'b1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [7:0]  exp_tx[$];
   logic [7:0]  exp_rx[$];
   logic [7:0]  txd_q[$];

   uart_stream_bridge #(
      .Bauds   (9_600),
      .Fclk    (9_600 * DIV),
      .TxDepth (TX_DEPTH),
      .RxDepth (RX_DEPTH)
   ) dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .TX_DATA  (TX_DATA),
      .TX_VALID (TX_VALID),
      .TX_READY (TX_READY),
      .RX_DATA  (RX_DATA),
      .RX_VALID (RX_VALID),
      .RX_READY (RX_READY),
      .TX_LEVEL (TX_LEVEL),
      .RX_LEVEL (RX_LEVEL),
      .RX_OVF   (RX_OVF),
      .OVF_CLR  (OVF_CLR),
      .IRQ      (IRQ),
      .TXD      (TXD),
      .RXD      (RXD)
   );

   always #5 CLK = ~CLK;

   // serial frame decoder on TXD: sample near the middle of each bit
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge TXD);
         repeat (DIV / 2) @(negedge CLK);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge CLK);
            b[i] = TXD;
         end
         repeat (DIV) @(negedge CLK);
         txd_q.push_back(b);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         RXD = f[i];
         repeat (DIV) @(negedge CLK);
      end
      repeat (4) @(negedge CLK);
   endtask

   task automatic tx_push(input logic [7:0] b);
      int unsigned n = 0;
      TX_DATA  = b;
      TX_VALID = 1'b1;
      while (!TX_READY && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      if (TX_READY) exp_tx.push_back(b);
      else          chk("tx_push_timeout", 0, 1);
      @(negedge CLK);
      TX_VALID = 1'b0;
   endtask

   task automatic tx_quiesce();
      int unsigned n = 0;
      while (TX_LEVEL != 0 && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 5000) chk("tx_quiesce_timeout", 0, 1);
      repeat (30 * DIV) @(negedge CLK);
      txd_q.delete();
      exp_tx.delete();
   endtask

   task automatic tx_compare(input string tag);
      int unsigned n = 0;
      while (txd_q.size() < exp_tx.size() && n < exp_tx.size() * 12 * DIV + 200) begin
         @(negedge CLK);
         n++;
      end
      repeat (12 * DIV) @(negedge CLK);
      chk({tag, "_frames"}, txd_q.size(), exp_tx.size());
      for (int i = 0; i < exp_tx.size() && i < txd_q.size(); i++)
         chk({tag, "_byte"}, txd_q[i], exp_tx[i]);
   endtask

   task automatic rx_drain(input string tag);
      RX_READY = 1'b1;
      for (int c = 0; c < RX_DEPTH + 4; c++) begin
         if (RX_VALID) begin
            if (exp_rx.size() != 0) chk({tag, "_data"}, RX_DATA, exp_rx.pop_front());
            else                    chk({tag, "_extra"}, 1, 0);
         end
         @(negedge CLK);
      end
      RX_READY = 1'b0;
      chk({tag, "_left"}, exp_rx.size(), 0);
      chk({tag, "_valid"}, RX_VALID, 0);
   endtask

   initial begin
      logic [7:0] b;
      logic [2:0] peak;

      #1 RSTN = 1'b0;
      repeat (3) @(negedge CLK);
      RSTN = 1'b1;
      @(negedge CLK);
      chk("rst_tx_ready", TX_READY, 1);
      chk("rst_rx_valid", RX_VALID, 0);
      chk("rst_tx_level", TX_LEVEL, 0);
      chk("rst_rx_level", RX_LEVEL, 0);
      chk("rst_rx_ovf", RX_OVF, 0);
      chk("rst_irq", IRQ, 0);
      chk("rst_txd", TXD, 1);

      // back-to-back burst
      tx_quiesce();
      peak = '0;
      for (int i = 0; i < 3; i++) begin
         b = 8'h41 + 8'(i);
         TX_DATA  = b;
         TX_VALID = 1'b1;
         chk("burst_ready", TX_READY, 1);
         exp_tx.push_back(b);
         @(negedge CLK);
         if (TX_LEVEL > peak) peak = TX_LEVEL;
      end
      TX_VALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (TX_LEVEL > peak) peak = TX_LEVEL;
      end
      chk("burst_peak", (peak == 3'd2) || (peak == 3'd3), 1);
      tx_compare("burst");

      // random bytes with random gaps, respecting TX_READY
      tx_quiesce();
      for (int i = 0; i < 6; i++) begin
         tx_push(8'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      tx_compare("tx_rand");

      // full TX FIFO: one byte leaves for the core, TX_DEPTH more fill the FIFO
      tx_quiesce();
      for (int i = 0; i < TX_DEPTH + 2; i++) begin
         b = 8'($urandom);
         TX_DATA  = b;
         TX_VALID = 1'b1;
         if (i <= TX_DEPTH) exp_tx.push_back(b);
         @(negedge CLK);
      end
      TX_VALID = 1'b0;
      chk("full_tx_ready", TX_READY, 0);
      chk("full_tx_level", TX_LEVEL, TX_DEPTH);
      tx_compare("full_tx");

      // random RX bytes, consumer stalled, then drained
      RX_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         exp_rx.push_back(b);
         send_rx(b);
      end
      chk("rx_rand_level", RX_LEVEL, 3);
      chk("rx_rand_irq", IRQ, 1);
      rx_drain("rx_rand");

      // overflow
      for (int i = 0; i < RX_DEPTH + 1; i++) begin
         b = 8'($urandom);
         if (i < RX_DEPTH) exp_rx.push_back(b);
         send_rx(b);
      end
      chk("ovf_level", RX_LEVEL, RX_DEPTH);
      chk("ovf_flag", RX_OVF, 1);
      chk("ovf_irq", IRQ, 1);
      rx_drain("ovf");
      chk("ovf_sticky_irq", IRQ, 1);
      OVF_CLR = 1'b1;
      @(negedge CLK);
      OVF_CLR = 1'b0;
      chk("ovf_clr_flag", RX_OVF, 0);
      chk("ovf_clr_irq", IRQ, 0);

      // full RX FIFO with push and pop in the same cycle
      for (int i = 0; i < RX_DEPTH; i++) begin
         b = 8'($urandom);
         exp_rx.push_back(b);
         send_rx(b);
      end
      chk("simul_pre_level", RX_LEVEL, RX_DEPTH);
      b = 8'($urandom);
      fork
         send_rx(b);
         begin : simul_watch
            int unsigned n = 0;
            while (!dut.w_int && n < 200) begin
               @(negedge CLK);
               n++;
            end
            chk("simul_int_seen", dut.w_int, 1);
            chk("simul_pop_data", RX_DATA, exp_rx.pop_front());
            RX_READY = 1'b1;
            @(negedge CLK);
            RX_READY = 1'b0;
         end
      join
      exp_rx.push_back(b);
      chk("simul_level", RX_LEVEL, RX_DEPTH);
      chk("simul_ovf", RX_OVF, 0);
      rx_drain("simul");

`ifdef UART_ECHO_EN
      tx_quiesce();
      fork
         send_rx(8'h5A);
         begin : echo_watch
            int unsigned n = 0;
            while (!dut.w_int && n < 200) begin
               @(negedge CLK);
               n++;
            end
            chk("echo_int_seen", dut.w_int, 1);
            TX_DATA  = 8'h77;
            TX_VALID = 1'b1;
            chk("echo_hold_ready", TX_READY, 0);
            @(negedge CLK);
            TX_VALID = 1'b0;
         end
      join
      exp_rx.push_back(8'h5A);
      exp_tx.push_back(8'h5A);
      chk("echo_rx_valid", RX_VALID, 1);
      tx_compare("echo_tx");
      rx_drain("echo_rx");
`endif

      // reset in the middle of a TX frame with RX data and overflow pending
      for (int i = 0; i < RX_DEPTH + 1; i++) send_rx(8'($urandom));
      chk("pre_rst_ovf", RX_OVF, 1);
      tx_push(8'($urandom));
      tx_push(8'($urandom));
      repeat (3 * DIV) @(negedge CLK);
      chk("pre_rst_tx_level", TX_LEVEL != 0, 1);
      #2 RSTN = 1'b0;
      #1;
      chk("midrst_txd", TXD, 1);
      chk("midrst_tx_level", TX_LEVEL, 0);
      chk("midrst_tx_ready", TX_READY, 1);
      chk("midrst_rx_valid", RX_VALID, 0);
      chk("midrst_rx_level", RX_LEVEL, 0);
      chk("midrst_rx_ovf", RX_OVF, 0);
      chk("midrst_irq", IRQ, 0);
      @(negedge CLK);
      RSTN = 1'b1;
      repeat (2) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
